ddr_uart_rx: RTL

DDR_UART_RX -- requirements
Module: ddr_uart_rx

---
 rtl/ddr_uart_rx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ddr_uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, optional parity,
// one-byte holding register with valid/ready handshake and error pulses.
//   clk, rst       : clock, synchronous active-high reset
//   uart_rxd       : asynchronous serial input, idles high
//   rx_data/valid  : held byte, consumed on rx_valid & rx_ready
//   rx_ready       : consumer accepts the held byte
//   frame_err      : 1-cycle pulse, stop bit sampled low
//   parity_err     : 1-cycle pulse, parity mismatch
//   overrun        : 1-cycle pulse, good byte dropped (holding reg full)
//   busy           : receiver is inside a frame
module ddr_uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;

  localparam logic [CW-1:0] BIT_END  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_CYC - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_err;
  logic          rxd_m;
  logic          rxd_s;
  logic          bit_end;

  assign bit_end = (cnt == BIT_END);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_err    <= 1'b0;
      rxd_m      <= 1'b1;
      rxd_s      <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rxd_m      <= uart_rxd;
      rxd_s      <= rxd_m;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      // Consumption; a byte completing in the STOP branch below overrides.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt     <= '0;
            bit_idx <= '0;
            par_err <= 1'b0;
            // Line back high at mid start bit: treat as a glitch.
            state   <= rxd_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shreg   <= {rxd_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt     <= '0;
            par_err <= ((^shreg) ^ rxd_s) != ODD;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            // Leave at mid stop bit so the next start edge is not missed.
            cnt        <= '0;
            state      <= IDLE;
            frame_err  <= ~rxd_s;
            parity_err <= par_err;
            if (rxd_s && !par_err) begin
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
